// File: rtl/t_tog_pkg.sv
// Shared types and helpers for the toggle-event decoder.
package t_tog_pkg;

    // Decoder occupancy state: empty, holding 1..DEPTH-1 events, holding DEPTH events
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_FULL = 2'd2
    } state_t;

    // Width of a counter that must represent 0..depth inclusive
    function automatic int pend_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/t_sync_ms.sv
// Master/slave two-flop synchroniser for an asynchronous level input.
// Both stages reset to INIT_LVL so that an idle link produces no event after reset.
module t_sync_ms #(
    parameter logic INIT_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic qm,
    output logic qs
);

    logic qm_q, qm_d;
    logic qs_q, qs_d;

    // Next-state: shift the input one stage per clock
    always_comb begin
        qm_d = d;
        qs_d = qm_q;
    end

    // Synchroniser registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qm_q <= INIT_LVL;
            qs_q <= INIT_LVL;
        end else begin
            qm_q <= qm_d;
            qs_q <= qs_d;
        end
    end

    assign qm = qm_q;
    assign qs = qs_q;

endmodule

// File: rtl/t_toggle_decoder.sv
// Receive end of a toggle-encoded event link. Each level change of tog_in
// becomes one event, up to DEPTH events are held pending, and events are
// handed to the consumer over a valid/ready handshake.
// Optional feature macro: TOG_ACK_EN adds the tog_ack return-toggle output.
module t_toggle_decoder
    import t_tog_pkg::*;
#(
    parameter int   DEPTH    = 4,
    parameter int   CW       = 8,
    parameter logic INIT_LVL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tog_in,
    input  logic          evt_ready,
    input  logic          ovf_clr,
    output logic          evt_valid,
    output logic [CW-1:0] evt_count,
    output logic          ovf,
    output logic          qm,
    output logic          qs
`ifdef TOG_ACK_EN
    ,
    output logic          tog_ack
`endif
);

    localparam int            PW      = pend_w(DEPTH);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic          qm_w, qs_w;
    logic          prev_q, prev_d;
    logic [PW-1:0] pending_q, pending_d;
    state_t        state_q, state_d;
    logic [CW-1:0] evt_count_q, evt_count_d;
    logic          ovf_q, ovf_d;
    logic          tog_edge;
    logic          accept;
    logic          drop;
`ifdef TOG_ACK_EN
    logic          tog_ack_q, tog_ack_d;
`endif

    t_sync_ms #(
        .INIT_LVL (INIT_LVL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (tog_in),
        .qm  (qm_w),
        .qs  (qs_w)
    );

    // Edge detect, pending bookkeeping and next-state derivation
    always_comb begin
        prev_d      = qs_w;
        tog_edge    = qs_w ^ prev_q;
        accept      = evt_valid & evt_ready;
        drop        = tog_edge & ~accept & (pending_q == DEPTH_P);

        // Edge and accept together cancel out, which keeps a full buffer full
        // without losing the incoming event.
        pending_d = pending_q;
        if (tog_edge && !accept && (pending_q != DEPTH_P)) begin
            pending_d = pending_q + 1'b1;
        end else if (!tog_edge && accept) begin
            pending_d = pending_q - 1'b1;
        end

        // State follows the occupancy the buffer will have after this clock
        if (pending_d == '0) begin
            state_d = S_IDLE;
        end else if (pending_d == DEPTH_P) begin
            state_d = S_FULL;
        end else begin
            state_d = S_PEND;
        end

        evt_count_d = evt_count_q;
        if (accept) begin
            evt_count_d = evt_count_q + CW'(1);
        end

        // A fresh drop overrides a simultaneous clear so it is never lost
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

`ifdef TOG_ACK_EN
        tog_ack_d = tog_ack_q ^ accept;
`endif
    end

    // Decoder state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= INIT_LVL;
            pending_q   <= '0;
            state_q     <= S_IDLE;
            evt_count_q <= '0;
            ovf_q       <= 1'b0;
`ifdef TOG_ACK_EN
            tog_ack_q   <= INIT_LVL;
`endif
        end else begin
            prev_q      <= prev_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            evt_count_q <= evt_count_d;
            ovf_q       <= ovf_d;
`ifdef TOG_ACK_EN
            tog_ack_q   <= tog_ack_d;
`endif
        end
    end

    // evt_valid comes straight from the state register, never from evt_ready
    assign evt_valid = (state_q != S_IDLE);
    assign evt_count = evt_count_q;
    assign ovf       = ovf_q;
    assign qm        = qm_w;
    assign qs        = qs_w;
`ifdef TOG_ACK_EN
    assign tog_ack   = tog_ack_q;
`endif

endmodule

// File: tb/tb_t_toggle_decoder.sv
// Directed testbench for t_toggle_decoder (DEPTH=4, CW=3, INIT_LVL=0).
module tb_t_toggle_decoder;
    import t_tog_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          rst;
    logic          tog_in;
    logic          evt_ready;
    logic          ovf_clr;
    logic          evt_valid;
    logic [CW-1:0] evt_count;
    logic          ovf;
    logic          qm;
    logic          qs;
`ifdef TOG_ACK_EN
    logic          tog_ack;
`endif

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt;
    int   acc;
    logic tog_lvl;

    t_toggle_decoder #(
        .DEPTH    (DEPTH),
        .CW       (CW),
        .INIT_LVL (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (tog_in),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_count (evt_count),
        .ovf       (ovf),
        .qm        (qm),
        .qs        (qs)
`ifdef TOG_ACK_EN
        ,
        .tog_ack   (tog_ack)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("  ok   %s = %0h", tag, obs);
        end else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle();
        tog_lvl = ~tog_lvl;
        tog_in  = tog_lvl;
    endtask

    initial begin
        rst       = 1'b1;
        tog_in    = 1'b0;
        tog_lvl   = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        exp_cnt   = 0;

        // 1: reset and idle
        nclk(3);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        rst = 1'b0;
        nclk(10);
        chk("t1_valid", 32'(evt_valid), 32'd0);
        chk("t1_count", 32'(evt_count), 32'd0);
        chk("t1_ovf", 32'(ovf), 32'd0);
        chk("t1_qm", 32'(qm), 32'd0);
        chk("t1_qs", 32'(qs), 32'd0);
`ifdef TOG_ACK_EN
        chk("t1_tog_ack", 32'(tog_ack), 32'd0);
`endif

        // 2: two sparse events with ready held high
        evt_ready = 1'b1;
        toggle();
        nclk(1);
        chk("t2_qm1", 32'(qm), 32'd1);
        chk("t2_qs0", 32'(qs), 32'd0);
        chk("t2a_valid_e1", 32'(evt_valid), 32'd0);
        nclk(1);
        chk("t2_qs1", 32'(qs), 32'd1);
        chk("t2a_valid_e2", 32'(evt_valid), 32'd0);
        nclk(1);
        chk("t2a_valid_e3", 32'(evt_valid), 32'd1);
        nclk(1);
        exp_cnt++;
        chk("t2a_valid_e4", 32'(evt_valid), 32'd0);
        chk("t2a_count", 32'(evt_count), 32'(exp_cnt % 8));
        nclk(36);
        toggle();
        nclk(2);
        chk("t2b_valid_e2", 32'(evt_valid), 32'd0);
        nclk(1);
        chk("t2b_valid_e3", 32'(evt_valid), 32'd1);
        nclk(1);
        exp_cnt++;
        chk("t2b_valid_e4", 32'(evt_valid), 32'd0);
        chk("t2b_count", 32'(evt_count), 32'(exp_cnt % 8));
        nclk(10);

        // 3: six events with no consumer, then drain
        evt_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            toggle();
            nclk(3);
            chk($sformatf("t3_valid_%0d", i), 32'(evt_valid), 32'd1);
            chk($sformatf("t3_pend_%0d", i), 32'(dut.pending_q), 32'((i > DEPTH) ? DEPTH : i));
            chk($sformatf("t3_ovf_%0d", i), 32'(ovf), 32'((i > DEPTH) ? 1 : 0));
            nclk(17);
        end
        chk("t3_state_full", 32'(dut.state_q), 32'(S_FULL));
        evt_ready = 1'b1;
        acc = 0;
        repeat (10) begin
            if (evt_valid) acc++;
            @(negedge clk);
        end
        evt_ready = 1'b0;
        exp_cnt += 4;
        chk("t3_accepts", 32'(acc), 32'd4);
        chk("t3_count", 32'(evt_count), 32'(exp_cnt % 8));
        chk("t3_valid_end", 32'(evt_valid), 32'd0);
        chk("t3_ovf_sticky", 32'(ovf), 32'd1);

        // 4: edge coinciding with accept while full; clear racing a drop
        ovf_clr = 1'b1;
        nclk(1);
        ovf_clr = 1'b0;
        chk("t4_ovf_cleared", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) begin
            toggle();
            nclk(5);
        end
        chk("t4_pend_full", 32'(dut.pending_q), 32'd4);
        toggle();
        nclk(2);
        evt_ready = 1'b1;
        nclk(1);
        evt_ready = 1'b0;
        exp_cnt++;
        chk("t4_pend_same", 32'(dut.pending_q), 32'd4);
        chk("t4_ovf_same", 32'(ovf), 32'd0);
        chk("t4_count_same", 32'(evt_count), 32'(exp_cnt % 8));
        chk("t4_valid_same", 32'(evt_valid), 32'd1);
        toggle();
        nclk(2);
        ovf_clr = 1'b1;
        nclk(1);
        ovf_clr = 1'b0;
        chk("t4_ovf_set_wins", 32'(ovf), 32'd1);
        chk("t4_pend_drop", 32'(dut.pending_q), 32'd4);
        nclk(1);
        ovf_clr = 1'b1;
        nclk(1);
        ovf_clr = 1'b0;
        chk("t4_ovf_clr_only", 32'(ovf), 32'd0);
        evt_ready = 1'b1;
        nclk(6);
        evt_ready = 1'b0;
        exp_cnt += 4;
        chk("t4_count_drain", 32'(evt_count), 32'(exp_cnt % 8));
        chk("t4_pend_drain", 32'(dut.pending_q), 32'd0);
        chk("t4_valid_drain", 32'(evt_valid), 32'd0);

        // 5: counter wrap with CW=3
        rst     = 1'b1;
        tog_lvl = 1'b0;
        tog_in  = 1'b0;
        nclk(2);
        rst     = 1'b0;
        exp_cnt = 0;
        nclk(2);
        chk("t5_count_rst", 32'(evt_count), 32'd0);
        evt_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            toggle();
            nclk(6);
            exp_cnt++;
            chk($sformatf("t5_count_%0d", i), 32'(evt_count), 32'(exp_cnt % 8));
        end
        chk("t5_count_final", 32'(evt_count), 32'd1);
`ifdef TOG_ACK_EN
        chk("t5_tog_ack", 32'(tog_ack), 32'd1);
`endif

        // 6: asynchronous reset with events pending, then a non-idle level at release
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            toggle();
            nclk(5);
        end
        chk("t6_pend3", 32'(dut.pending_q), 32'd3);
        chk("t6_valid_pre", 32'(evt_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid_async", 32'(evt_valid), 32'd0);
        chk("t6_pend_async", 32'(dut.pending_q), 32'd0);
        chk("t6_count_async", 32'(evt_count), 32'd0);
`ifdef TOG_ACK_EN
        chk("t6_tog_ack_rst", 32'(tog_ack), 32'd0);
`endif
        toggle();
        nclk(2);
        rst = 1'b0;
        nclk(1);
        chk("t6_qm_rel", 32'(qm), 32'd1);
        chk("t6_valid_rel1", 32'(evt_valid), 32'd0);
        nclk(1);
        chk("t6_valid_rel2", 32'(evt_valid), 32'd0);
        nclk(1);
        chk("t6_valid_rel3", 32'(evt_valid), 32'd1);
        chk("t6_pend_rel", 32'(dut.pending_q), 32'd1);
        evt_ready = 1'b1;
        nclk(1);
        chk("t6_valid_acc", 32'(evt_valid), 32'd0);
        chk("t6_count_acc", 32'(evt_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
